// File: rtl/otp_access_sched.sv
// rtl/otp_access_sched.sv - OTP engine access scheduler
// Serializes boot autoload, host read and host program onto otp_main with gap, timeout and boot retry.
module otp_access_sched #(
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13,
  parameter int BOOT_RETRY  = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       i_i2c_busy,
  input  logic       i_run_test_mode,
  input  logic       i_req_rd,
  input  logic       i_req_pgm,
  output logic       o_gnt_rd,
  output logic       o_gnt_pgm,
  output logic       o_done_rd,
  output logic       o_done_pgm,
  output logic       o_err_rd,
  output logic       o_err_pgm,
  output logic       o_eng_start,
  output logic [1:0] o_eng_op,
  output logic       o_eng_abort,
  input  logic       i_eng_done,
  output logic       o_boot_done,
  output logic       o_boot_fail,
  output logic       o_timeout_flag
);

  localparam logic [1:0]       OP_BOOT   = 2'b00;
  localparam logic [1:0]       OP_RD     = 2'b01;
  localparam logic [1:0]       OP_PGM    = 2'b10;
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(BOOT_RETRY);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] counter, counter_n;
  logic [1:0]       op, op_n;
  logic             boot_pend, boot_pend_n;
  logic [3:0]       retry_cnt, retry_n;
  logic [1:0]       starve_cnt, starve_n;
  logic             boot_done, boot_done_n;
  logic             boot_fail, boot_fail_n;
  logic             timeout_flag, timeout_flag_n;
  logic             pgm_ok;
  logic             owned;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      op           <= OP_BOOT;
      boot_pend    <= 1'b1;
      retry_cnt    <= '0;
      starve_cnt   <= '0;
      boot_done    <= 1'b0;
      boot_fail    <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_n;
      counter      <= counter_n;
      op           <= op_n;
      boot_pend    <= boot_pend_n;
      retry_cnt    <= retry_n;
      starve_cnt   <= starve_n;
      boot_done    <= boot_done_n;
      boot_fail    <= boot_fail_n;
      timeout_flag <= timeout_flag_n;
    end
  end

  always_comb begin
    state_n        = state;
    counter_n      = counter;
    op_n           = op;
    boot_pend_n    = boot_pend;
    retry_n        = retry_cnt;
    starve_n       = starve_cnt;
    boot_done_n    = boot_done;
    boot_fail_n    = boot_fail;
    timeout_flag_n = timeout_flag;
    o_eng_start    = 1'b0;
    o_eng_abort    = 1'b0;
    o_done_rd      = 1'b0;
    o_done_pgm     = 1'b0;
    o_err_rd       = 1'b0;
    o_err_pgm      = 1'b0;
    pgm_ok         = i_req_pgm & i_run_test_mode;
    owned          = (state == LAUNCH) || (state == WAIT);
    o_gnt_rd       = owned && (op == OP_RD);
    o_gnt_pgm      = owned && (op == OP_PGM);

    case (state)
      IDLE: begin
        if (counter == '0 && !i_i2c_busy) begin
          if (boot_pend) begin
            op_n    = OP_BOOT;
            state_n = LAUNCH;
          end else if (pgm_ok && (!i_req_rd || starve_cnt == 2'd2)) begin
            op_n     = OP_PGM;
            starve_n = '0;
            state_n  = LAUNCH;
          end else if (i_req_rd) begin
            // a read that jumps a waiting program counts toward the starvation guard
            op_n    = OP_RD;
            state_n = LAUNCH;
            if (pgm_ok) starve_n = starve_cnt + 2'd1;
          end
        end
      end
      LAUNCH: begin
        o_eng_start = 1'b1;
        counter_n   = '0;
        state_n     = WAIT;
      end
      WAIT: begin
        counter_n = counter + 1'b1;
        if (i_eng_done) begin
          o_done_rd  = (op == OP_RD);
          o_done_pgm = (op == OP_PGM);
          if (op == OP_BOOT) begin
            boot_pend_n = 1'b0;
            boot_done_n = 1'b1;
          end
          counter_n = GAP_LOAD;
          state_n   = GAP;
        end else if (counter == TO_LAST) begin
          o_eng_abort    = 1'b1;
          o_err_rd       = (op == OP_RD);
          o_err_pgm      = (op == OP_PGM);
          timeout_flag_n = 1'b1;
          if (op == OP_BOOT) begin
            if (retry_cnt < RETRY_MAX) begin
              retry_n = retry_cnt + 4'd1;
            end else begin
              boot_pend_n = 1'b0;
              boot_done_n = 1'b1;
              boot_fail_n = 1'b1;
            end
          end
          counter_n = GAP_LOAD;
          state_n   = GAP;
        end
      end
      GAP: begin
        if (counter == '0) state_n = IDLE;
        else               counter_n = counter - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_eng_op       = op;
  assign o_boot_done    = boot_done;
  assign o_boot_fail    = boot_fail;
  assign o_timeout_flag = timeout_flag;

endmodule

// File: tb/tb_otp_access_sched.sv
// tb/tb_otp_access_sched.sv - self-checking bench for otp_access_sched
// Scenario tasks with a behavioural arbitration model, an engine responder and an event log.
module tb_otp_access_sched;
  localparam int GAP_CYC     = 4;
  localparam int TIMEOUT_CYC = 4096;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_i2c_busy = 1'b0, i_run_test_mode = 1'b0, i_req_rd = 1'b0, i_req_pgm = 1'b0;
  logic       i_eng_done = 1'b0;
  logic       o_gnt_rd, o_gnt_pgm, o_done_rd, o_done_pgm, o_err_rd, o_err_pgm;
  logic       o_eng_start, o_eng_abort, o_boot_done, o_boot_fail, o_timeout_flag;
  logic [1:0] o_eng_op;

  int errors = 0, checks = 0;
  int cyc = 0;
  int resp_lat = 10, resp_cnt = -1;
  int st_cyc[$], dn_cyc[$], ab_cyc[$];
  logic [1:0] st_op[$];
  int n_done_rd = 0, n_done_pgm = 0, n_err_rd = 0, n_err_pgm = 0, bad_gnt = 0;
  int model_starve = 0;

  otp_access_sched #(.GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(13), .BOOT_RETRY(2)) dut (
    .sys_clk(sys_clk), .rst(rst), .i_i2c_busy(i_i2c_busy), .i_run_test_mode(i_run_test_mode),
    .i_req_rd(i_req_rd), .i_req_pgm(i_req_pgm), .o_gnt_rd(o_gnt_rd), .o_gnt_pgm(o_gnt_pgm),
    .o_done_rd(o_done_rd), .o_done_pgm(o_done_pgm), .o_err_rd(o_err_rd), .o_err_pgm(o_err_pgm),
    .o_eng_start(o_eng_start), .o_eng_op(o_eng_op), .o_eng_abort(o_eng_abort),
    .i_eng_done(i_eng_done), .o_boot_done(o_boot_done), .o_boot_fail(o_boot_fail),
    .o_timeout_flag(o_timeout_flag)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  // engine model: done pulse resp_lat cycles after start, never when resp_lat==0
  always @(negedge sys_clk) begin
    i_eng_done = 1'b0;
    if (rst) resp_cnt = -1;
    else if (resp_cnt == 0) begin i_eng_done = 1'b1; resp_cnt = -1; end
    else if (resp_cnt > 0) resp_cnt--;
    #1;
    if (o_eng_start && resp_lat > 0) resp_cnt = resp_lat - 1;
  end

  always @(negedge sys_clk) begin
    #2;
    if (o_eng_start) begin st_cyc.push_back(cyc); st_op.push_back(o_eng_op); end
    if (o_done_rd || o_done_pgm) dn_cyc.push_back(cyc);
    if (o_eng_abort) ab_cyc.push_back(cyc);
    if (o_done_rd) n_done_rd++;
    if (o_done_pgm) n_done_pgm++;
    if (o_err_rd) n_err_rd++;
    if (o_err_pgm) n_err_pgm++;
    if ((o_gnt_rd && o_gnt_pgm) || (o_gnt_rd && o_eng_op != 2'b01) || (o_gnt_pgm && o_eng_op != 2'b10) ||
        (o_eng_start && o_eng_op != 2'b00 && !(o_gnt_rd || o_gnt_pgm)))
      bad_gnt++;
  end

  function automatic logic [1:0] model_pick(input bit rd, input bit pe);
    if (pe && (!rd || model_starve >= 2)) begin model_starve = 0; return 2'b10; end
    if (rd) begin if (pe) model_starve++; return 2'b01; end
    return 2'b11;
  endfunction

  task automatic wait_starts(input int n, input int budget, output bit ok);
    int k = 0;
    while (st_cyc.size() < n && k < budget) begin @(negedge sys_clk); #3; k++; end
    ok = (st_cyc.size() >= n);
  endtask

  task automatic wait_dones(input int n, input int budget, output bit ok);
    int k = 0;
    while (dn_cyc.size() < n && k < budget) begin @(negedge sys_clk); #3; k++; end
    ok = (dn_cyc.size() >= n);
  endtask

  task automatic clear_log();
    st_cyc.delete(); st_op.delete(); dn_cyc.delete(); ab_cyc.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    #3;
    checks++;
    if ({o_gnt_rd, o_gnt_pgm, o_done_rd, o_done_pgm, o_err_rd, o_err_pgm, o_eng_start, o_eng_op,
         o_eng_abort, o_boot_done, o_boot_fail, o_timeout_flag} !== 14'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {o_gnt_rd, o_gnt_pgm, o_done_rd,
        o_done_pgm, o_err_rd, o_err_pgm, o_eng_start, o_eng_op, o_eng_abort, o_boot_done, o_boot_fail, o_timeout_flag});
    end
    checks++;
    if (st_cyc.size() !== 0) begin errors++; $display("FAIL reset_no_start: starts=%0d expected 0", st_cyc.size()); end
  endtask

  task automatic test_boot_busy();
    bit ok; int rel, k;
    clear_log();
    @(negedge sys_clk); i_i2c_busy = 1'b1; i_req_rd = 1'b1; resp_lat = 10; rst = 1'b0;
    repeat (20) @(negedge sys_clk);
    #3;
    checks++;
    if (st_cyc.size() !== 0) begin errors++; $display("FAIL busy_hold: starts=%0d expected 0", st_cyc.size()); end
    @(negedge sys_clk); i_i2c_busy = 1'b0; rel = cyc;
    wait_starts(1, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL boot_start: no start expected at cycle %0d", rel + 1); return; end
    else if (st_cyc[0] != rel + 1) begin errors++; $display("FAIL boot_start: cycle %0d expected %0d", st_cyc[0], rel + 1); end
    checks++;
    if (st_op[0] !== 2'b00) begin errors++; $display("FAIL boot_op: got %b expected 00", st_op[0]); end
    k = 0;
    while (!o_boot_done && k < 40) begin @(negedge sys_clk); #3; k++; end
    checks++;
    if (cyc != st_cyc[0] + 11) begin errors++; $display("FAIL boot_done_time: cycle %0d expected %0d", cyc, st_cyc[0] + 11); end
    checks++;
    if ({o_boot_fail, o_timeout_flag} !== 2'b00) begin errors++; $display("FAIL boot_ok_flags: got %b expected 00", {o_boot_fail, o_timeout_flag}); end
    wait_starts(2, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL boot_gap: no read start expected at %0d", st_cyc[0] + 10 + GAP_CYC + 2); return; end
    else if (st_cyc[1] != st_cyc[0] + 10 + GAP_CYC + 2 || st_op[1] !== 2'b01) begin
      errors++; $display("FAIL boot_gap: read start cycle %0d op %b expected %0d op 01", st_cyc[1], st_op[1], st_cyc[0] + 10 + GAP_CYC + 2);
    end
    @(negedge sys_clk); i_req_rd = 1'b0;
    wait_dones(1, 20, ok);
    checks++;
    if (!ok || dn_cyc[0] != st_cyc[1] + 10) begin errors++; $display("FAIL read_done_time: ok %0d cycle %0d expected %0d", ok, ok ? dn_cyc[0] : -1, st_cyc[1] + 10); end
    repeat (15) @(negedge sys_clk);
    #3;
    checks++;
    if (st_cyc.size() != 2) begin errors++; $display("FAIL dropped_no_reserve: starts=%0d expected 2", st_cyc.size()); end
  endtask

  task automatic test_arb_starve();
    bit ok; logic [1:0] exp;
    clear_log();
    model_starve = 0;
    resp_lat = $urandom_range(1, 12);
    @(negedge sys_clk); i_run_test_mode = 1'b1; i_req_rd = 1'b1; i_req_pgm = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_starts(i + 1, resp_lat + 30, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL starve_slot%0d: no start", i); return; end
      exp = model_pick(1'b1, 1'b1);
      if (st_op[i] !== exp) begin errors++; $display("FAIL starve_slot%0d: op %b expected %b", i, st_op[i], exp); end
      if (i > 0) begin
        checks++;
        if (st_cyc[i] != dn_cyc[i-1] + GAP_CYC + 2) begin
          errors++; $display("FAIL starve_gap%0d: start %0d expected %0d", i, st_cyc[i], dn_cyc[i-1] + GAP_CYC + 2);
        end
      end
    end
    @(negedge sys_clk); i_req_rd = 1'b0; i_req_pgm = 1'b0;
    wait_dones(6, resp_lat + 30, ok);
    repeat (15) @(negedge sys_clk);
    #3;
    checks++;
    if (!ok || st_cyc.size() != 6) begin errors++; $display("FAIL starve_end: done_ok %0d starts=%0d expected 6", ok, st_cyc.size()); end
  endtask

  task automatic test_testmode_gate();
    bit ok; int c, dr0, dp0, er0, ep0;
    clear_log();
    dr0 = n_done_rd; dp0 = n_done_pgm; er0 = n_err_rd; ep0 = n_err_pgm;
    resp_lat = 6;
    @(negedge sys_clk); i_i2c_busy = 1'b1; i_req_rd = 1'b1; i_run_test_mode = 1'b0;
    repeat (5) @(negedge sys_clk);
    i_req_rd = 1'b0;
    @(negedge sys_clk); i_i2c_busy = 1'b0; i_req_pgm = 1'b1;
    repeat (20) @(negedge sys_clk);
    #3;
    checks++;
    if (st_cyc.size() != 0 || n_done_rd != dr0 || n_done_pgm != dp0 || n_err_rd != er0 || n_err_pgm != ep0) begin
      errors++; $display("FAIL gated_idle: starts=%0d pulses=%0d expected 0", st_cyc.size(),
        n_done_rd - dr0 + n_done_pgm - dp0 + n_err_rd - er0 + n_err_pgm - ep0);
    end
    @(negedge sys_clk); i_run_test_mode = 1'b1; c = cyc;
    wait_starts(1, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tm_start: no start expected at %0d", c + 1); return; end
    else if (st_cyc[0] != c + 1 || st_op[0] !== 2'b10) begin
      errors++; $display("FAIL tm_start: cycle %0d op %b expected %0d op 10", st_cyc[0], st_op[0], c + 1);
    end
    @(negedge sys_clk); i_req_pgm = 1'b0; i_run_test_mode = 1'b0;
    wait_dones(1, 20, ok);
    checks++;
    if (!ok || n_done_pgm != dp0 + 1 || dn_cyc[0] != st_cyc[0] + 6) begin
      errors++; $display("FAIL pgm_done: count %0d cycle %0d expected 1 at %0d", n_done_pgm - dp0, ok ? dn_cyc[0] : -1, st_cyc[0] + 6);
    end
  endtask

  task automatic test_done_at_timeout();
    bit ok; int dr0, er0, k;
    clear_log();
    dr0 = n_done_rd; er0 = n_err_rd;
    resp_lat = TIMEOUT_CYC;
    @(negedge sys_clk); i_req_rd = 1'b1;
    wait_starts(1, 20, ok);
    @(negedge sys_clk); i_req_rd = 1'b0;
    wait_dones(1, TIMEOUT_CYC + 20, ok);
    checks++;
    if (!ok || dn_cyc[0] != st_cyc[0] + TIMEOUT_CYC) begin
      errors++; $display("FAIL edge_done: ok %0d cycle %0d expected %0d", ok, ok ? dn_cyc[0] : -1, st_cyc[0] + TIMEOUT_CYC);
    end
    checks++;
    if (n_err_rd != er0 || ab_cyc.size() != 0 || o_timeout_flag !== 1'b0) begin
      errors++; $display("FAIL edge_no_err: err %0d abort %0d flag %b expected 0 0 0", n_err_rd - er0, ab_cyc.size(), o_timeout_flag);
    end
    resp_lat = TIMEOUT_CYC + 1;
    @(negedge sys_clk); i_req_rd = 1'b1;
    wait_starts(2, 20, ok);
    @(negedge sys_clk); i_req_rd = 1'b0;
    k = 0;
    while (ab_cyc.size() == 0 && k < TIMEOUT_CYC + 20) begin @(negedge sys_clk); #3; k++; end
    repeat (10) @(negedge sys_clk);
    #3;
    checks++;
    if (!ok || ab_cyc.size() != 1 || ab_cyc[0] != st_cyc[1] + TIMEOUT_CYC) begin
      errors++; $display("FAIL rd_timeout: aborts %0d cycle %0d expected 1 at %0d", ab_cyc.size(), ab_cyc.size() ? ab_cyc[0] : -1, st_cyc[1] + TIMEOUT_CYC);
    end
    checks++;
    if (n_err_rd != er0 + 1 || n_done_rd != dr0 + 1 || o_timeout_flag !== 1'b1 || o_boot_fail !== 1'b0) begin
      errors++; $display("FAIL rd_timeout_flags: err %0d done %0d flag %b fail %b expected 1 1 1 0",
        n_err_rd - er0, n_done_rd - dr0, o_timeout_flag, o_boot_fail);
    end
  endtask

  task automatic test_random_traffic();
    bit ok, r_rd, r_pg, r_tm, have_prev;
    logic [1:0] exp;
    int n, m, dp0;
    have_prev = 1'b0;
    for (int r = 0; r < 30; r++) begin
      r_rd = 1'($urandom); r_pg = 1'($urandom); r_tm = 1'($urandom);
      if (!r_rd && !(r_pg && r_tm)) r_rd = 1'b1;
      resp_lat = $urandom_range(1, 25);
      n = st_cyc.size(); m = dn_cyc.size(); dp0 = n_done_pgm;
      i_req_rd = r_rd; i_req_pgm = r_pg; i_run_test_mode = r_tm;
      exp = model_pick(r_rd, r_pg && r_tm);
      wait_starts(n + 1, 40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand%0d_start: none", r); return; end
      else if (st_op[n] !== exp) begin errors++; $display("FAIL rand%0d_op: got %b expected %b (rd %b pg %b tm %b)", r, st_op[n], exp, r_rd, r_pg, r_tm); end
      if (have_prev) begin
        checks++;
        if (st_cyc[n] != dn_cyc[m-1] + GAP_CYC + 2) begin
          errors++; $display("FAIL rand%0d_gap: start %0d expected %0d", r, st_cyc[n], dn_cyc[m-1] + GAP_CYC + 2);
        end
      end
      @(negedge sys_clk); i_req_rd = 1'b0; i_req_pgm = 1'b0; i_run_test_mode = 1'($urandom);
      wait_dones(m + 1, 40, ok);
      checks++;
      if (!ok || (n_done_pgm - dp0) != ((exp == 2'b10) ? 1 : 0)) begin
        errors++; $display("FAIL rand%0d_done: ok %0d pgm_done %0d expected op %b", r, ok, n_done_pgm - dp0, exp);
        return;
      end
      have_prev = 1'b1;
    end
  endtask

  task automatic test_boot_timeout();
    bit ok; int k, er0, ep0, dr0;
    clear_log();
    er0 = n_err_rd; ep0 = n_err_pgm; dr0 = n_done_rd;
    resp_lat = 0;
    @(negedge sys_clk); i_req_rd = 1'b1; i_req_pgm = 1'b0; i_run_test_mode = 1'b0; i_i2c_busy = 1'b0; rst = 1'b1;
    @(negedge sys_clk); rst = 1'b0; model_starve = 0;
    wait_starts(3, 2 * (TIMEOUT_CYC + 10) + 20, ok);
    resp_lat = 5;
    k = 0;
    while (!o_boot_done && k < TIMEOUT_CYC + 20) begin @(negedge sys_clk); #3; k++; end
    checks++;
    if (!ok || ab_cyc.size() != 3) begin errors++; $display("FAIL boot_retry_count: starts %0d aborts %0d expected 3 3", st_cyc.size(), ab_cyc.size()); return; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (st_op[i] !== 2'b00 || ab_cyc[i] != st_cyc[i] + TIMEOUT_CYC) begin
        errors++; $display("FAIL boot_try%0d: op %b abort %0d expected 00 at %0d", i, st_op[i], ab_cyc[i], st_cyc[i] + TIMEOUT_CYC);
      end
    end
    checks++;
    if ({o_boot_done, o_boot_fail, o_timeout_flag} !== 3'b111 || n_err_rd != er0 || n_err_pgm != ep0) begin
      errors++; $display("FAIL boot_fail_flags: got %b err %0d expected 111 err 0", {o_boot_done, o_boot_fail, o_timeout_flag}, n_err_rd - er0 + n_err_pgm - ep0);
    end
    wait_starts(4, 20, ok);
    checks++;
    if (!ok || st_op[3] !== 2'b01 || st_cyc[3] != ab_cyc[2] + GAP_CYC + 2) begin
      errors++; $display("FAIL post_fail_read: ok %0d cycle %0d expected op 01 at %0d", ok, ok ? st_cyc[3] : -1, ab_cyc[2] + GAP_CYC + 2);
    end
    @(negedge sys_clk); i_req_rd = 1'b0;
    wait_dones(1, 20, ok);
    checks++;
    if (!ok || n_done_rd != dr0 + 1) begin errors++; $display("FAIL post_fail_done: count %0d expected 1", n_done_rd - dr0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_log();
    resp_lat = 0;
    @(negedge sys_clk); i_run_test_mode = 1'b1; i_req_pgm = 1'b1;
    wait_starts(1, 20, ok);
    repeat (5) @(negedge sys_clk);
    #1;
    checks++;
    if (!ok || o_gnt_pgm !== 1'b1 || st_op[0] !== 2'b10) begin errors++; $display("FAIL mid_pgm_grant: gnt %b expected 1", o_gnt_pgm); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({o_gnt_rd, o_gnt_pgm, o_done_rd, o_done_pgm, o_err_rd, o_err_pgm, o_eng_start, o_eng_op,
         o_eng_abort, o_boot_done, o_boot_fail, o_timeout_flag} !== 14'h0 || ab_cyc.size() != 0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h aborts %0d expected 0 0", {o_gnt_rd, o_gnt_pgm, o_done_rd,
        o_done_pgm, o_err_rd, o_err_pgm, o_eng_start, o_eng_op, o_eng_abort, o_boot_done, o_boot_fail, o_timeout_flag}, ab_cyc.size());
    end
    resp_lat = 3;
    @(negedge sys_clk); rst = 1'b0;
    wait_starts(3, 40, ok);
    checks++;
    if (!ok || st_op[1] !== 2'b00 || st_op[2] !== 2'b10) begin
      errors++; $display("FAIL mid_reset_reboot: ok %0d ops %b %b expected 00 10", ok, st_op[1], st_op[2]);
    end
    @(negedge sys_clk); i_req_pgm = 1'b0;
    wait_dones(1, 20, ok);
    checks++;
    if (!ok || o_boot_done !== 1'b1 || o_boot_fail !== 1'b0) begin
      errors++; $display("FAIL mid_reset_after: done_ok %0d boot_done %b boot_fail %b expected 1 1 0", ok, o_boot_done, o_boot_fail);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (bad_gnt != 0) begin errors++; $display("FAIL grant_invariant: violations %0d expected 0", bad_gnt); end
  endtask

  initial begin
    test_reset();
    test_boot_busy();
    test_arb_starve();
    test_testmode_gate();
    test_done_at_timeout();
    test_random_traffic();
    test_boot_timeout();
    test_reset_mid();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
